// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO result registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CW = 16;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [2:0]    op_q;
    logic [CW-1:0] count;

    logic          accept;
    logic [63:0]   prod;
    logic          neg_a;
    logic          neg_b;
    logic [31:0]   mag_a;
    logic [31:0]   mag_b;
    logic [31:0]   div_b;
    logic [31:0]   uq;
    logic [31:0]   ur;
    logic [31:0]   quot;
    logic [31:0]   rem;

    assign busy   = (count != '0);
    assign accept = start && (count == '0) && (mdop != 3'd0) && (mdop != 3'd7);

    // Sign-extending to 64 bits makes the truncated product the correct two's complement result.
    always_comb begin
        prod = '0;
        if (op_q == OP_MULT)
            prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        else
            prod = {32'd0, a_q} * {32'd0, b_q};
    end

    // Signed divide via magnitudes: avoids the host trap on 0x80000000 / -1 and wraps instead.
    always_comb begin
        neg_a = (op_q == OP_DIV) && a_q[31];
        neg_b = (op_q == OP_DIV) && b_q[31];
        mag_a = neg_a ? (32'd0 - a_q) : a_q;
        mag_b = neg_b ? (32'd0 - b_q) : b_q;
        div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
        uq    = mag_a / div_b;
        ur    = mag_a % div_b;
        quot  = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
        rem   = neg_a ? (32'd0 - ur) : ur;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            count <= '0;
            HI    <= '0;
            LO    <= '0;
        end else if (count != '0) begin
            count <= count - 1'b1;
            if (count == CW'(1)) begin
                if (op_q == OP_MULT || op_q == OP_MULTU) begin
                    HI <= prod[63:32];
                    LO <= prod[31:0];
                end else if (b_q != 32'd0) begin
                    HI <= rem;
                    LO <= quot;
                end
            end
        end else if (accept) begin
            case (mdop)
                OP_MTHI: HI <= A;
                OP_MTLO: LO <= A;
                default: begin
                    a_q   <= A;
                    b_q   <= B;
                    op_q  <= mdop;
                    count <= (mdop == OP_DIV || mdop == OP_DIVU) ? CW'(DIV_CYCLES)
                                                                 : CW'(MULT_CYCLES);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - table-driven self-checking bench for md_unit
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp;
    int n_err;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        mdop  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        mdop  = 3'd0;
    endtask

    initial begin
        logic [31:0] mhi;
        logic [31:0] mlo;
        int          n;
        logic        stable;
        logic        zero_ok;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        start = 1'b0;
        mdop  = 3'd0;
        A     = '0;
        B     = '0;

        vt[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vt[1]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vt[2]  = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
        vt[3]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
        vt[4]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vt[5]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vt[6]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vt[7]  = '{3'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 10};
        vt[8]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vt[9]  = '{3'd4, 32'd100,      32'd7,        32'd2,        32'd14,       10};
        vt[10] = '{3'd4, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
        vt[11] = '{3'd5, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0FFFFFFF, 0};
        vt[12] = '{3'd6, 32'h00000001, 32'h0,        32'hDEADBEEF, 32'h00000001, 0};
        vt[13] = '{3'd5, 32'h12345678, 32'h0,        32'h12345678, 32'h00000001, 0};
        vt[14] = '{3'd6, 32'h12345678, 32'h0,        32'h12345678, 32'h12345678, 0};
        vt[15] = '{3'd4, 32'h00000007, 32'h0,        32'h12345678, 32'h12345678, 10};
        vt[16] = '{3'd3, 32'h00000007, 32'h0,        32'h12345678, 32'h12345678, 10};
        vt[17] = '{3'd0, 32'h00000001, 32'h1,        32'h12345678, 32'h12345678, 0};
        vt[18] = '{3'd7, 32'h00000002, 32'h1,        32'h12345678, 32'h12345678, 0};

        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        reset = 1'b1;
        mhi = 32'd0;
        mlo = 32'd0;

        for (int i = 0; i < 19; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b);
            n = 0;
            stable = 1'b1;
            while (busy === 1'b1 && n < 40) begin
                if (HI !== mhi || LO !== mlo) stable = 1'b0;
                n++;
                @(negedge clk);
            end
            chk($sformatf("v%0d_busy_cycles", i), n, vt[i].cyc);
            chk($sformatf("v%0d_stable", i), {31'd0, stable}, 32'd1);
            chk($sformatf("v%0d_hi", i), HI, vt[i].hi);
            chk($sformatf("v%0d_lo", i), LO, vt[i].lo);
            mhi = vt[i].hi;
            mlo = vt[i].lo;
        end

        // DIVU accepted, then MULT start held through the edge where busy falls
        @(negedge clk);
        start = 1'b1;
        mdop  = 3'd4;
        A     = 32'd100;
        B     = 32'd7;
        @(negedge clk);
        mdop  = 3'd1;
        A     = 32'hFFFFFFFE;
        B     = 32'd3;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        mdop  = 3'd0;
        chk("hold_busy_cycles", n, 10);
        chk("hold_hi", HI, 32'd2);
        chk("hold_lo", LO, 32'd14);
        @(negedge clk);
        chk("hold_no_accept_on_fall", {31'd0, busy}, 32'd0);
        chk("hold_hi_after", HI, 32'd2);
        chk("hold_lo_after", LO, 32'd14);

        // Reset pulse in the middle of a multiply
        issue(3'd1, 32'd3, 32'd3);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        chk("async_reset_hi", HI, 32'd0);
        chk("async_reset_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        zero_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) zero_ok = 1'b0;
        end
        chk("post_reset_quiet", {31'd0, zero_ok}, 32'd1);

        // First edge after reset release must accept
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        mdop  = 3'd5;
        A     = 32'h0000A5A5;
        @(negedge clk);
        start = 1'b0;
        mdop  = 3'd0;
        chk("first_edge_accept_hi", HI, 32'h0000A5A5);
        chk("first_edge_accept_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request strobe, sampled each rising edge.
REQ-006 SHALL have port mdop  input  3  operation: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 0 and 7 are no-op.
REQ-007 SHALL have port A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO source).
REQ-008 SHALL have port B  input  32  operand rt (divisor / multiplier).
REQ-009 SHALL have port busy  output  1  high while a multiply/divide is in flight.
REQ-010 SHALL have port HI  output  32  HI register, registered output.
REQ-011 SHALL have port LO  output  32  LO register, registered output.

Function
REQ-012 SHALL accept a request on a rising edge only when start=1, busy=0 and mdop is 1..6.
REQ-013 SHALL ignore start while busy=1: no operand capture, no counter reload, no HI/LO change.
REQ-014 SHALL, on accepting MULT/MULTU/DIV/DIVU, capture A, B and mdop into internal registers at that edge.
REQ-015 SHALL load a down-counter with MULT_CYCLES (mul) or DIV_CYCLES (div) on acceptance; busy = (counter != 0).
REQ-016 SHALL decrement the counter by 1 on every edge while nonzero; busy is high for exactly N cycles after the accepting edge.
REQ-017 SHALL write HI/LO on the edge where the counter goes 1 -> 0, so results are visible after edge t+N for acceptance at edge t.
REQ-018 SHALL for MULT form the 64-bit signed product of captured A, B; MULTU the unsigned product; HI = bits 63:32, LO = bits 31:0.
REQ-019 SHALL for DIV set LO = signed quotient truncated toward zero and HI = remainder with the sign of the dividend.
REQ-020 SHALL for DIVU set LO = unsigned quotient and HI = unsigned remainder.
REQ-021 SHALL on DIV/DIVU with captured B = 0 still run DIV_CYCLES busy cycles and leave HI and LO unchanged.
REQ-022 SHALL compute DIV with A = 0x80000000, B = 0xFFFFFFFF as LO = 0x80000000, HI = 0 (wrap, no trap).
REQ-023 SHALL on accepted MTHI write HI = A at the accepting edge, LO unchanged, busy stays 0.
REQ-024 SHALL on accepted MTLO write LO = A at the accepting edge, HI unchanged, busy stays 0.
REQ-025 SHALL accept a new request on the same edge where the counter reaches 0 only if busy was already 0 before that edge; the edge where busy falls is not an accepting edge.
REQ-026 SHALL leave HI/LO stable on every edge other than those in REQ-017, REQ-023 and REQ-024.
REQ-027 SHALL ignore mdop 0 and 7 with start=1: no state change.
REQ-028 SHALL hold HI/LO outputs and busy purely from registers (no combinational path from inputs).

Reset
REQ-029 SHALL, while reset=0, force busy=0, counter=0, HI=0, LO=0 immediately without waiting for clk.
REQ-030 SHALL abort any in-flight operation on reset assertion; no result is written after reset deasserts.
REQ-031 SHALL accept a request on the first rising edge after reset returns to 1.

Verification
REQ-032 SHALL pass: MULT A=0xFFFFFFFE (-2), B=3 at edge t -> busy high 5 cycles, after edge t+5 HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 SHALL pass: MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 SHALL pass: DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU A=7, B=0 with HI=LO=0x12345678 preloaded via MTHI/MTLO -> HI, LO unchanged after 10 cycles.
REQ-035 SHALL pass: DIVU A=100, B=7 accepted, then MULT start held on cycles 2..9 -> all ignored, final LO=14, HI=2, busy=0 after cycle 10.
REQ-036 SHALL pass: MTHI A=0xDEADBEEF -> HI=0xDEADBEEF after that edge, busy never asserted; MTLO A=0x1 -> LO=1.
REQ-037 SHALL pass: MULT accepted, reset pulsed low for half a cycle at cycle 3 -> busy, HI, LO read 0 during reset and remain 0 through cycle 10.
